// File: rtl/operand_issue.sv
// VR16 decode and operand-issue stage: register file, writeback, scoreboard
// hazard detection and the registered operand bundle handed to the ALU.
module operand_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        issue_valid,
  output logic [3:0]  _opcode,
  output logic [3:0]  _imm_value,
  output logic [15:0] operand_one,
  output logic [15:0] operand_two,
  output logic [3:0]  issue_rd,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [15:0] scoreboard
);

  logic [15:0] rf [16];

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic        writes_rd;
  logic        reads_rs2;
  logic [15:0] clr_mask;
  logic [15:0] pending;
  logic        hazard;
  logic        accept;
  logic [15:0] src1_val;
  logic [15:0] src2_val;
  logic [15:0] sb_next;

  assign op  = instr[15:12];
  assign rd  = instr[11:8];
  assign rs1 = instr[7:4];
  assign rs2 = instr[3:0];

  always_comb begin
    writes_rd = 1'b1;
    reads_rs2 = 1'b1;
    case (op)
      4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1101: reads_rs2 = 1'b0;
      4'b1000, 4'b1001, 4'b1010, 4'b1111:          writes_rd = 1'b0;
      default: ;
    endcase
  end

  // A bit being cleared by this cycle's writeback no longer blocks issue.
  assign clr_mask = wb_en ? (16'd1 << wb_addr) : 16'd0;
  assign pending  = scoreboard & ~clr_mask;

  assign hazard = pending[rs1]
               || (reads_rs2 && pending[rs2])
               || (writes_rd && pending[rd]);

  assign instr_ready = reset && !hazard;
  assign accept      = instr_valid && instr_ready;

  always_comb begin
    src1_val = rf[rs1];
    src2_val = rf[rs2];
    if (wb_en && wb_addr == rs1) src1_val = wb_data;
    if (wb_en && wb_addr == rs2) src2_val = wb_data;
    if (rs1 == 4'd0) src1_val = 16'd0;
    if (rs2 == 4'd0) src2_val = 16'd0;
  end

  // Clear first, then set, so an issue and a writeback to the same rd keep the bit.
  always_comb begin
    sb_next = scoreboard;
    if (wb_en) sb_next[wb_addr] = 1'b0;
    if (accept && writes_rd && rd != 4'd0) sb_next[rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'd0;
      scoreboard  <= 16'd0;
      issue_valid <= 1'b0;
      _opcode     <= 4'd0;
      _imm_value  <= 4'd0;
      operand_one <= 16'd0;
      operand_two <= 16'd0;
      issue_rd    <= 4'd0;
    end else begin
      if (wb_en && wb_addr != 4'd0) rf[wb_addr] <= wb_data;
      scoreboard <= sb_next;
      if (accept) begin
        issue_valid <= 1'b1;
        _opcode     <= op;
        _imm_value  <= rs2;
        operand_one <= src1_val;
        operand_two <= src2_val;
        issue_rd    <= rd;
      end else begin
        issue_valid <= 1'b0;
        _opcode     <= 4'd0;
        _imm_value  <= 4'd0;
        operand_one <= 16'd0;
        operand_two <= 16'd0;
        issue_rd    <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: reset, independent issue, RAW bypass,
// WAW set-wins, r0/control behaviour and reset during a stall.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        issue_valid;
  logic [3:0]  _opcode;
  logic [3:0]  _imm_value;
  logic [15:0] operand_one;
  logic [15:0] operand_two;
  logic [3:0]  issue_rd;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] scoreboard;

  int n_checks = 0;
  int n_fail   = 0;

  operand_issue dut (
    .clk(clk), .reset(reset),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .issue_valid(issue_valid), ._opcode(_opcode), ._imm_value(_imm_value),
    .operand_one(operand_one), .operand_two(operand_two), .issue_rd(issue_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .scoreboard(scoreboard)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] i,
                       input logic we, input logic [3:0] wa, input logic [15:0] wd);
    instr_valid = v;
    instr       = i;
    wb_en       = we;
    wb_addr     = wa;
    wb_data     = wd;
    #1;
  endtask

  task automatic chk_issue(input string tag, input logic [3:0] op, input logic [3:0] rd,
                           input logic [15:0] a, input logic [15:0] b);
    chk({tag, "_valid"}, issue_valid, 1);
    chk({tag, "_op"}, _opcode, op);
    chk({tag, "_rd"}, issue_rd, rd);
    chk({tag, "_a"}, operand_one, a);
    chk({tag, "_b"}, operand_two, b);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, issue_valid, 0);
    chk({tag, "_op"}, _opcode, 0);
    chk({tag, "_a"}, operand_one, 0);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 16'h0, 0, 0, 0);

    // Reset held with random stimulus
    for (int k = 0; k < 3; k++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            4'($urandom), 16'($urandom));
      step();
      chk("rst_ready", instr_ready, 0);
      chk("rst_valid", issue_valid, 0);
      chk("rst_sb", scoreboard, 0);
      chk("rst_ops", {_opcode, _imm_value, issue_rd, operand_one, operand_two}, 0);
    end
    drive(0, 16'h0, 0, 0, 0);
    reset = 1'b1;
    #1;
    chk("rel_ready", instr_ready, 1);

    // Independent issue
    drive(1, 16'h1105, 0, 0, 0);
    chk("addi1_ready", instr_ready, 1);
    step();
    chk_issue("addi1", 4'h1, 4'h1, 16'd0, 16'd0);
    chk("addi1_imm", _imm_value, 5);
    chk("addi1_sb", scoreboard, 16'h0002);
    drive(1, 16'h1203, 0, 0, 0);
    step();
    chk("addi2_valid", issue_valid, 1);
    chk("addi2_imm", _imm_value, 3);
    chk("addi2_sb", scoreboard, 16'h0006);
    drive(0, 16'h0, 1, 4'd1, 16'd5);
    step();
    chk_bubble("bub1");
    chk("wb1_sb", scoreboard, 16'h0004);
    drive(0, 16'h0, 1, 4'd2, 16'd3);
    step();
    chk("wb2_sb", scoreboard, 16'h0000);

    // RAW stall with bypass
    drive(1, 16'h0312, 0, 0, 0);
    step();
    chk_issue("add", 4'h0, 4'h3, 16'd5, 16'd3);
    chk("add_sb", scoreboard, 16'h0008);
    drive(1, 16'h2431, 0, 0, 0);
    chk("sub_stall_ready", instr_ready, 0);
    step();
    chk_bubble("sub_stall");
    chk("sub_stall_ready2", instr_ready, 0);
    drive(1, 16'h2431, 1, 4'd3, 16'd8);
    chk("sub_rel_ready", instr_ready, 1);
    step();
    chk_issue("sub", 4'h2, 4'h4, 16'd8, 16'd5);
    chk("sub_sb", scoreboard, 16'h0010);
    drive(0, 16'h0, 1, 4'd4, 16'd3);
    step();
    chk("wb4_sb", scoreboard, 16'h0000);

    // WAW: second write to r5 held until r5 writeback; set wins on that edge
    drive(1, 16'h5512, 0, 0, 0);
    step();
    chk("muli_a", operand_one, 16'd5);
    chk("muli_imm", _imm_value, 2);
    chk("muli_sb", scoreboard, 16'h0020);
    drive(1, 16'h6512, 0, 0, 0);
    chk("andr_stall_ready", instr_ready, 0);
    step();
    chk_bubble("andr_stall");
    drive(1, 16'h6512, 1, 4'd5, 16'd10);
    chk("andr_rel_ready", instr_ready, 1);
    step();
    chk_issue("andr", 4'h6, 4'h5, 16'd5, 16'd3);
    chk("andr_sb_setwins", scoreboard, 16'h0020);
    drive(0, 16'h0, 1, 4'd5, 16'd1);
    step();
    chk("wb5_sb", scoreboard, 16'h0000);

    // r0 destination and control opcodes leave the scoreboard alone
    drive(1, 16'h0012, 0, 0, 0);
    step();
    chk_issue("add_r0", 4'h0, 4'h0, 16'd5, 16'd3);
    chk("add_r0_sb", scoreboard, 16'h0000);
    drive(1, 16'h9320, 0, 0, 0);
    step();
    chk_issue("jump", 4'h9, 4'h3, 16'd3, 16'd0);
    chk("jump_sb", scoreboard, 16'h0000);
    drive(1, 16'h9001, 1, 4'd0, 16'hFFFF);
    step();
    chk("r0_nobypass_a", operand_one, 16'd0);
    chk("r0_nobypass_b", operand_two, 16'd5);
    drive(1, 16'hF000, 0, 0, 0);
    step();
    chk("r0_nowrite_a", operand_one, 16'd0);
    chk("r0_nowrite_b", operand_two, 16'd0);

    // Reset mid-stall
    drive(1, 16'h1307, 0, 0, 0);
    step();
    chk("addi3_sb", scoreboard, 16'h0008);
    drive(1, 16'h2431, 0, 0, 0);
    chk("rs_stall_ready", instr_ready, 0);
    step();
    chk_bubble("rs_stall");
    reset = 1'b0;
    #1;
    chk("rs_sb", scoreboard, 16'h0000);
    chk("rs_ready", instr_ready, 0);
    step();
    chk("rs_hold_valid", issue_valid, 0);
    reset = 1'b1;
    #1;
    chk("rs_rel_ready", instr_ready, 1);
    step();
    chk_issue("rs_sub", 4'h2, 4'h4, 16'd0, 16'd0);
    chk("rs_sub_sb", scoreboard, 16'h0010);
    drive(0, 16'h0, 1, 4'd4, 16'd0);
    step();
    chk("rs_wb4_sb", scoreboard, 16'h0000);
    for (int i = 1; i < 16; i++) begin
      drive(1, {4'hF, 4'h0, 4'(i), 4'(i)}, 0, 0, 0);
      step();
      chk($sformatf("rs_r%0d_a", i), operand_one, 16'd0);
      chk($sformatf("rs_r%0d_b", i), operand_two, 16'd0);
    end

    // Writeback with no scoreboard bit set still writes
    drive(0, 16'h0, 1, 4'd7, 16'hBEEF);
    step();
    chk("wb_free_sb", scoreboard, 16'h0000);
    drive(1, 16'hF070, 0, 0, 0);
    step();
    chk_issue("wb_free_rd", 4'hF, 4'h0, 16'hBEEF, 16'd0);
    drive(0, 16'h0, 0, 0, 0);
    step();
    chk_bubble("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
# operand_issue

Decode-and-operand-issue stage of VR16, sitting directly upstream of the ALU. It accepts 16-bit instructions over a valid/ready handshake and decodes them. It reads the 16×16 register file and drives registered `_opcode`, `_imm_value`, `operand_one` and `operand_two` to the ALU. It also owns register-file writeback and a per-register scoreboard that stalls on read-after-write and write-after-write hazards.

## Interface
- No parameters. Fixed: 16 registers, 16-bit data, instruction format `[15:12]` opcode, `[11:8]` rd, `[7:4]` rs1, `[3:0]` rs2/imm.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low. Asserted when 0.
- `instr` in 16: instruction word.
- `instr_valid` in 1: `instr` is valid this cycle.
- `instr_ready` out 1: the stage accepts `instr` this cycle.
- `issue_valid` out 1: the registered outputs below hold a real instruction.
- `_opcode` out 4: opcode to ALU.
- `_imm_value` out 4: `instr[3:0]`, zero-extended by the ALU.
- `operand_one` out 16: rs1 value.
- `operand_two` out 16: rs2 value.
- `issue_rd` out 4: destination register, forwarded for writeback tagging.
- `wb_en` in 1: writeback strobe.
- `wb_addr` in 4: writeback register index.
- `wb_data` in 16: writeback data, normally the ALU `result`.
- `scoreboard` out 16: bit n set means register n has a write pending.

## Operation
- **Opcode classes**
  - Register-register, writes rd and reads rs1/rs2: 0000, 0010, 0100, 0110, 1011, 1100, 1110.
  - Immediate, writes rd and reads rs1: 0001, 0011, 0101, 0111.
  - NOT, writes rd and reads rs1: 1101.
  - Control (LOAD/JUMP/STORE/1111), reads rs1/rs2 and does not write rd: 1000, 1001, 1010, 1111.
- **Register file**
  - r0 always reads 0. Writes to r0 are ignored, and r0 is never scoreboarded.
  - A write occurs on a clock edge with `wb_en`=1 and `wb_addr`≠0.
- **Read bypass:** if `wb_en`=1 and `wb_addr` equals a source index (≠0) in the same cycle, that operand takes `wb_data`.
- **Hazard** (combinational). A hazard exists when any of the following holds, where "pending" means the scoreboard bit is set and it is not being cleared by `wb_en`/`wb_addr` this cycle:
  - rs1 is pending.
  - rs2 is pending and the opcode reads rs2.
  - rd is pending and the opcode writes rd.
- **Ready:** `instr_ready` = !hazard while `reset` is deasserted; it is 0 while `reset`=0. `instr_ready` does not depend on `instr_valid`.
- **Accept:** occurs on an edge with `instr_valid`&&`instr_ready`.
  - The outputs register the decoded fields and operands, and `issue_valid` goes to 1.
  - If the opcode writes rd and rd≠0, `scoreboard[rd]` is set.
- **Bubble:** on any edge without an accept, `issue_valid`=0, `_opcode`=0000, and `_imm_value`, `operand_one`, `operand_two`, `issue_rd` = 0. The ALU therefore computes 0+0.
- **Scoreboard update:** `wb_en` clears `scoreboard[wb_addr]`. If a set and a clear target the same register on the same edge, the set wins.
- **Reset:** asynchronous. Clears all 16 registers, `scoreboard`, `issue_valid`, and all issue outputs to 0.

## Timing
- Issue latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- The ALU result is ready after edge N+1. The downstream writeback is expected at edge N+2 (`wb_en` asserted in the cycle before it).
- Throughput is 1 instruction per cycle when independent.
- A dependent instruction stalls until the cycle in which its pending register's `wb_en` is presented. It is accepted on that edge, using the bypassed `wb_data`.
- A writeback to a register without its scoreboard bit set is legal and performs the write.
- Reset asserted mid-stall or mid-issue: all state clears immediately. Any in-flight writeback arriving after reset is honoured as an ordinary write.

## Test plan
- **Reset:** hold `reset`=0 with random `instr`/`instr_valid` → all outputs 0, `instr_ready`=0, `scoreboard`=0. Release → `instr_ready`=1.
- **Independent issue:**
  - Stimulus: back-to-back `ADDI r1,r0,5` (0x1105) then `ADDI r2,r0,3` (0x1203), each with writeback `wb_data` of 5 and 3.
  - Required response: issued on consecutive cycles with `_imm_value` 5 and 3; `scoreboard`=0x0006 then clears.
- **RAW stall with bypass:**
  - Stimulus: after r1=5 and r2=3 are written, issue `ADD r3,r1,r2` (0x0312) then `SUB r4,r3,r1` (0x2431).
  - Required response: `instr_ready`=0 until `wb_en`/`wb_addr`=3/`wb_data`=8; SUB is accepted on that edge with `operand_one`=8 and `operand_two`=5.
- **WAW:**
  - Stimulus: `MULI r5,r1,2` then `ANDR r5,...` with no writeback.
  - Required response: the second instruction is held. Writeback to r5 releases it, and `scoreboard[5]` is set again on that same edge (set wins).
- **r0 and control:**
  - Stimulus: `ADD r0,r1,r2` and `JUMP` (0x9xxx).
  - Required response: `scoreboard` unchanged; `wb_addr`=0 writes are ignored; r0 reads 0.
- **Reset mid-stall:**
  - Stimulus: pending r3 with a dependent instruction stalled; pulse `reset`=0.
  - Required response: `scoreboard`=0, r1..r15 read 0, and the stalled instruction is accepted on the first edge after release.
